// File: rtl/diagv2_ecall_unit_pkg.sv
// Shared constants for the ECALL service unit: syscall codes and FSM state encodings.
// States are plain 3-bit constants so they line up with the legacy const header.
package diagv2_ecall_unit_pkg;

  localparam int DEF_SYS_PRINT = 4;
  localparam int DEF_SYS_EXIT  = 93;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  // The last byte lane of a line forces a refetch of the following line.
  function automatic logic is_last_lane(input logic [2:0] offset);
    return offset == 3'd7;
  endfunction

endpackage

// File: rtl/diagv2_ecall_byte_sel.sv
// Picks one little-endian byte lane out of a buffered dmem line and flags the string terminator.
module diagv2_ecall_byte_sel #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_line,
  input  logic [2:0]        i_offset,
  output logic [7:0]        o_byte,
  output logic              o_is_null
);

  assign o_byte    = i_line[{i_offset, 3'b000} +: 8];
  assign o_is_null = (o_byte == 8'h00);

endmodule

// File: rtl/diagv2_ecall_unit.sv
// ECALL service unit: freezes the core, runs PRINT (dmem string -> console) and EXIT,
// and flags unknown syscall codes.
module diagv2_ecall_unit
  import diagv2_ecall_unit_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int LINE_AW   = 12,
  parameter int MAX_LEN   = 4096,
  parameter int SYS_PRINT = DEF_SYS_PRINT,
  parameter int SYS_EXIT  = DEF_SYS_EXIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ecall,
  input  logic [DATA_W-1:0]  syscall_id,
  input  logic [DATA_W-1:0]  arg0,
  output logic               stall,
  output logic               mem_req,
  output logic [LINE_AW-1:0] mem_line,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               con_valid,
  output logic [7:0]         con_data,
  input  logic               con_ready,
  output logic               exited,
  output logic [DATA_W-1:0]  exit_code,
  output logic               bad_ecall,
  output logic               truncated
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic [2:0]         r_state;
  logic [LINE_AW-1:0] r_line;
  logic [2:0]         r_offset;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_buf;
  logic [DATA_W-1:0]  r_exit_code;
  logic               r_exited;
  logic               r_bad_ecall;
  logic               r_truncated;

  logic [7:0] w_byte;
  logic       w_is_null;
  logic       w_at_cap;
  logic       w_emit;
  logic       w_handshake;

  diagv2_ecall_byte_sel #(.DATA_W(DATA_W)) u_byte_sel (
    .i_line   (r_buf),
    .i_offset (r_offset),
    .o_byte   (w_byte),
    .o_is_null(w_is_null)
  );

  assign w_at_cap    = (r_count == CNT_W'(MAX_LEN));
  assign w_emit      = (r_state == ST_EMIT) && !w_is_null && !w_at_cap;
  assign w_handshake = w_emit && con_ready;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_line      <= '0;
      r_offset    <= '0;
      r_count     <= '0;
      // NOTE: the line buffer is reset too, so con_data cannot show stale bytes after reset.
      r_buf       <= '0;
      r_exit_code <= '0;
      r_exited    <= 1'b0;
      r_bad_ecall <= 1'b0;
      r_truncated <= 1'b0;
    end else begin
      r_bad_ecall <= 1'b0;
      r_truncated <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ecall) begin
            if (syscall_id == DATA_W'(SYS_EXIT)) begin
              r_state     <= ST_HALTED;
              r_exit_code <= arg0;
              r_exited    <= 1'b1;
            end else if (syscall_id == DATA_W'(SYS_PRINT)) begin
              r_state  <= ST_FETCH;
              r_line   <= arg0[LINE_AW+2:3];
              r_offset <= arg0[2:0];
              r_count  <= '0;
            end else begin
              r_state     <= ST_DONE;
              r_bad_ecall <= 1'b1;
            end
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_buf   <= mem_rdata;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_is_null) begin
            r_state <= ST_DONE;
          end else if (w_at_cap) begin
            r_state     <= ST_DONE;
            r_truncated <= 1'b1;
          end else if (w_handshake) begin
            r_count  <= r_count + CNT_W'(1);
            r_offset <= r_offset + 3'd1;
            if (is_last_lane(r_offset)) begin
              r_line  <= r_line + LINE_AW'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE:   r_state <= ST_IDLE;
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // The ECALL cycle itself must freeze the core, hence the combinational term.
  assign stall     = (r_state != ST_IDLE) | (ecall & (r_state == ST_IDLE));
  assign mem_req   = (r_state == ST_FETCH);
  assign mem_line  = r_line;
  assign con_valid = w_emit;
  assign con_data  = w_emit ? w_byte : 8'h00;
  assign exited    = r_exited;
  assign exit_code = r_exit_code;
  assign bad_ecall = r_bad_ecall;
  assign truncated = r_truncated;

endmodule

// File: tb/tb_diagv2_ecall_unit.sv
// Self-checking bench for diagv2_ecall_unit: byte-addressed dmem model, string-walk
// reference model, per-cycle scoreboard, and hand-computed literal expectations.
module tb_diagv2_ecall_unit;

  localparam int DATA_W  = 64;
  localparam int LINE_AW = 12;
  localparam int MAX_LEN = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ecall = 1'b0;
  logic [DATA_W-1:0] syscall_id = '0;
  logic [DATA_W-1:0] arg0 = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              con_ready = 1'b1;
  logic              stall, mem_req, con_valid, exited, bad_ecall, truncated;
  logic [LINE_AW-1:0] mem_line;
  logic [7:0]        con_data;
  logic [DATA_W-1:0] exit_code;

  always #5 clk = ~clk;

  diagv2_ecall_unit #(.DATA_W(DATA_W), .LINE_AW(LINE_AW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .ecall(ecall), .syscall_id(syscall_id), .arg0(arg0),
    .stall(stall), .mem_req(mem_req), .mem_line(mem_line), .mem_rdata(mem_rdata),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .exited(exited), .exit_code(exit_code), .bad_ecall(bad_ecall), .truncated(truncated)
  );

  // dmem second read port: data valid exactly one cycle after the request.
  logic [DATA_W-1:0] dmem [0:4095];
  always @(posedge clk) if (mem_req) mem_rdata <= dmem[mem_line];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Console ready driver: a level, or a repeating 1,0,0,1 pattern.
  logic       rdy_mode = 1'b0;
  logic       rdy_level = 1'b1;
  logic [3:0] rdy_pat = 4'b1001;
  int         rdy_idx = 0;
  always @(posedge clk) begin
    #1;
    con_ready = rdy_mode ? rdy_pat[rdy_idx % 4] : rdy_level;
    rdy_idx++;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: walk the string byte by byte in a flat byte address space.
  logic [7:0] exp_bytes [$];
  int         exp_lines [$];
  int         exp_trunc;

  function automatic logic [7:0] mem_byte(input int a);
    logic [63:0] w;
    w = dmem[(a >> 3) % 4096];
    return w[(a % 8) * 8 +: 8];
  endfunction

  task automatic model_print(input int a0);
    int a;
    int n;
    logic [7:0] b;
    a = a0;
    n = 0;
    exp_bytes.delete();
    exp_lines.delete();
    exp_trunc = 0;
    exp_lines.push_back((a >> 3) % 4096);
    while (1) begin
      b = mem_byte(a);
      if (b == 8'h00) break;
      if (n == MAX_LEN) begin
        exp_trunc = 1;
        break;
      end
      exp_bytes.push_back(b);
      n++;
      a++;
      if (a % 8 == 0) exp_lines.push_back((a >> 3) % 4096);
    end
  endtask

  // Captured activity for the hand-computed literal checks.
  logic [7:0] got_bytes [$];
  int         got_cyc [$];
  int         got_lines [$];
  int         n_bad, n_trunc, n_hold;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic clear_capture();
    got_bytes.delete();
    got_cyc.delete();
    got_lines.delete();
    n_bad = 0;
    n_trunc = 0;
    n_hold = 0;
  endtask

  // Compare process: checks every request and handshake against the model at mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_hold++;
        check("hold_con_valid", con_valid, 1'b1);
        check("hold_con_data", con_data, prev_data);
      end
      if (mem_req) begin
        got_lines.push_back(mem_line);
        check("mem_req_expected", exp_lines.size() != 0, 1'b1);
        if (exp_lines.size() != 0) check("mem_line", mem_line, exp_lines.pop_front());
      end
      if (con_valid && con_ready) begin
        got_bytes.push_back(con_data);
        got_cyc.push_back(cyc);
        check("byte_expected", exp_bytes.size() != 0, 1'b1);
        if (exp_bytes.size() != 0) check("con_data", con_data, exp_bytes.pop_front());
      end
      if (bad_ecall) n_bad++;
      if (truncated) n_trunc++;
      prev_hold = con_valid && !con_ready;
      prev_data = con_data;
    end
  end

  task automatic do_ecall(input logic [63:0] id, input logic [63:0] a, output int stall_cycles);
    @(posedge clk); #1;
    ecall = 1'b1; syscall_id = id; arg0 = a;
    #1;
    check("stall_on_ecall_cycle", stall, 1'b1);
    stall_cycles = 1;
    @(posedge clk); #1;
    ecall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stall) break;
      stall_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_bytes.delete();
    exp_lines.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic load_line(input int ln, input logic [63:0] w);
    dmem[ln] = w;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    int n;
    logic [63:0] w;
    for (int i = 0; i < 4096; i++) dmem[i] = '0;
    clear_capture();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_con_valid", con_valid, 1'b0);
    check("rst_exited", exited, 1'b0);
    check("rst_exit_code", exit_code, 64'd0);
    check("rst_pulses", {bad_ecall, truncated, con_data}, 10'd0);
    reset = 1'b1;

    // 1. EXIT with a0=7
    @(posedge clk); #1;
    ecall = 1'b1; syscall_id = 64'd93; arg0 = 64'd7;
    #1;
    check("t1_stall_same_cycle", stall, 1'b1);
    check("t1_exited_not_yet", exited, 1'b0);
    @(posedge clk); #1;
    ecall = 1'b0;
    check("t1_exited", exited, 1'b1);
    check("t1_exit_code", exit_code, 64'd7);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (stall) n++;
      if (i == 10) begin ecall = 1'b1; syscall_id = 64'd93; arg0 = 64'd9; end
      if (i == 11) begin ecall = 1'b1; syscall_id = 64'd4;  arg0 = 64'h20; end
      if (i == 12) ecall = 1'b0;
      @(posedge clk); #1;
    end
    check("t1_stall_100_cycles", n, 100);
    check("t1_exit_code_kept", exit_code, 64'd7);
    check("t1_no_fetch_when_halted", got_lines.size(), 0);
    pulse_reset();
    check("t1_exited_cleared", exited, 1'b0);

    // 2. "Hi\n" at 0x20
    load_line(4, 64'h0000_0000_000A_6948);
    clear_capture();
    model_print(32'h20);
    do_ecall(64'd4, 64'h20, sc);
    check("t2_stall_cycles", sc, 8);
    check("t2_nbytes", got_bytes.size(), 3);
    check("t2_byte0", got_bytes[0], 8'h48);
    check("t2_byte1", got_bytes[1], 8'h69);
    check("t2_byte2", got_bytes[2], 8'h0A);
    check("t2_back_to_back_01", got_cyc[1] - got_cyc[0], 1);
    check("t2_back_to_back_12", got_cyc[2] - got_cyc[1], 1);
    check("t2_nreq", got_lines.size(), 1);
    check("t2_req_line", got_lines[0], 4);
    check("t2_model_drained", exp_bytes.size() + exp_lines.size(), 0);

    // 3. "ABCD" at 0x26 crossing line 4 -> 5
    load_line(4, 64'h4241_0000_0000_0000);
    load_line(5, 64'h0000_0000_0000_4443);
    clear_capture();
    model_print(32'h26);
    do_ecall(64'd4, 64'h26, sc);
    check("t3_stall_cycles", sc, 11);
    check("t3_nbytes", got_bytes.size(), 4);
    check("t3_byte2", got_bytes[2], 8'h43);
    check("t3_byte3", got_bytes[3], 8'h44);
    check("t3_gap_B_to_C", got_cyc[2] - got_cyc[1], 3);
    check("t3_req_lines", {got_lines.size(), got_lines[0], got_lines[1]}, {32'd2, 32'd4, 32'd5});
    check("t3_model_drained", exp_bytes.size() + exp_lines.size(), 0);

    // 4. Backpressure with con_ready pattern 1,0,0,1
    load_line(8, 64'h0000_0000_5A59_5857);
    clear_capture();
    model_print(32'h40);
    rdy_mode = 1'b1;
    do_ecall(64'd4, 64'h40, sc);
    rdy_mode = 1'b0;
    check("t4_terminated", stall, 1'b0);
    check("t4_nbytes", got_bytes.size(), 4);
    check("t4_last_byte", got_bytes[3], 8'h5A);
    check("t4_saw_backpressure", n_hold != 0, 1'b1);
    check("t4_model_drained", exp_bytes.size() + exp_lines.size(), 0);

    // 5. Unknown syscall
    clear_capture();
    exp_bytes.delete();
    exp_lines.delete();
    do_ecall(64'd5, 64'h20, sc);
    check("t5_stall_cycles", sc, 2);
    check("t5_bad_pulses", n_bad, 1);
    check("t5_no_req", got_lines.size(), 0);
    check("t5_not_exited", exited, 1'b0);

    // 6. Truncation at MAX_LEN=16 over a 32-byte non-null region at 0x80
    for (int ln = 16; ln < 20; ln++) begin
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'h61 + 8'((ln - 16) * 8 + b);
      load_line(ln, w);
    end
    clear_capture();
    model_print(32'h80);
    check("t6_model_truncates", exp_trunc, 1);
    do_ecall(64'd4, 64'h80, sc);
    check("t6_stall_cycles", sc, 25);
    check("t6_nbytes", got_bytes.size(), 16);
    check("t6_last_byte", got_bytes[15], 8'h70);
    check("t6_trunc_pulses", n_trunc, 1);
    check("t6_req_lines", {got_lines.size(), got_lines[0], got_lines[2]}, {32'd3, 32'd16, 32'd18});
    check("t6_model_drained", exp_bytes.size() + exp_lines.size(), 0);

    // Reset asserted while a byte is being presented
    load_line(4, 64'h0000_0000_000A_6948);
    clear_capture();
    model_print(32'h20);
    rdy_level = 1'b0;
    @(posedge clk); #1;
    ecall = 1'b1; syscall_id = 64'd4; arg0 = 64'h20;
    @(posedge clk); #1;
    ecall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (con_valid) break;
      @(posedge clk); #1;
    end
    check("r_reached_emit", con_valid, 1'b1);
    reset = 1'b0;
    exp_bytes.delete();
    exp_lines.delete();
    #1;
    check("r_con_valid_dropped", con_valid, 1'b0);
    check("r_idle_no_stall", stall, 1'b0);
    check("r_no_byte_sent", got_bytes.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    rdy_level = 1'b1;
    @(posedge clk); #1;
    clear_capture();
    model_print(32'h20);
    do_ecall(64'd4, 64'h20, sc);
    check("r_new_print_stall", sc, 8);
    check("r_new_print_nbytes", got_bytes.size(), 3);
    check("r_new_print_byte0", got_bytes[0], 8'h48);
    check("r_model_drained", exp_bytes.size() + exp_lines.size(), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
